mul_iter: RTL and testbench

Iterative 32x32→64 shift-add multiplier that serves as the responder for the execute stage's multi-cycle multiply handshake (mult/multu). The execute stage drives operands, signedness and start, and stalls the pipeline until ready_o pulses. The product is written to HI/LO: high word to HI, low word to LO.

---
 rtl/mul_iter_pkg.sv | 19 +
 rtl/mul_iter_if.sv | 22 ++
 rtl/mul_iter.sv | 136 +++++++++++++
 tb/tb_mul_iter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_iter_pkg.sv
// Shared constants and FSM encoding for the iterative multiplier.
// Handshake levels mirror the divider so the execute-stage control logic is symmetric.
package mul_iter_pkg;

  localparam logic MulStart          = 1'b1;
  localparam logic MulStop           = 1'b0;
  localparam logic MulResultReady    = 1'b1;
  localparam logic MulResultNotReady = 1'b0;

  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic [63:0] ZeroDword = {ZeroWord, ZeroWord};

  typedef enum logic [1:0] {
    MulFree = 2'b00,
    MulOn   = 2'b01,
    MulEnd  = 2'b10
  } mul_state_e;

endpackage

// File: rtl/mul_iter_if.sv
// Multiply handshake between the execute stage (master) and the multiplier (slave).
interface mul_iter_if;

  logic        signed_mul_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_mul_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_mul_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/mul_iter.sv
// Iterative 32x32->64 shift-add multiplier: one partial product per cycle,
// 32 steps on unsigned magnitudes with the sign applied on the last step.
module mul_iter
  import mul_iter_pkg::*;
(
  input logic       clk,
  input logic       rst,
  mul_iter_if.slave mul
);

  mul_state_e  state_r, state_nx_s;
  logic [63:0] acc_r, acc_nx_s;
  logic [63:0] mcand_r, mcand_nx_s;
  logic [31:0] mplier_r, mplier_nx_s;
  logic [4:0]  cnt_r, cnt_nx_s;
  logic        neg_r, neg_nx_s;
  logic [63:0] result_r, result_nx_s;
  logic        ready_r, ready_nx_s;
  logic [31:0] mag1_s, mag2_s;
  logic [63:0] acc_step_s;

  // Operand magnitudes; 0x80000000 negates to itself, which is the right unsigned magnitude
  always_comb begin
    if (mul.signed_mul_i && mul.opdata1_i[31]) begin
      mag1_s = ~mul.opdata1_i + 32'd1;
    end else begin
      mag1_s = mul.opdata1_i;
    end
    if (mul.signed_mul_i && mul.opdata2_i[31]) begin
      mag2_s = ~mul.opdata2_i + 32'd1;
    end else begin
      mag2_s = mul.opdata2_i;
    end
  end

  // Accumulator after the current shift-add step
  always_comb begin
    if (mplier_r[0]) begin
      acc_step_s = acc_r + mcand_r;
    end else begin
      acc_step_s = acc_r;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx_s  = state_r;
    acc_nx_s    = acc_r;
    mcand_nx_s  = mcand_r;
    mplier_nx_s = mplier_r;
    cnt_nx_s    = cnt_r;
    neg_nx_s    = neg_r;
    result_nx_s = ZeroDword;
    ready_nx_s  = MulResultNotReady;

    case (state_r)
      MulOn: begin
        if (mul.annul_i) begin
          state_nx_s = MulFree;
        end else begin
          acc_nx_s    = acc_step_s;
          mcand_nx_s  = {mcand_r[62:0], 1'b0};
          mplier_nx_s = {1'b0, mplier_r[31:1]};
          cnt_nx_s    = cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            state_nx_s = MulEnd;
            ready_nx_s = MulResultReady;
            if (neg_r) begin
              result_nx_s = ~acc_step_s + 64'd1;
            end else begin
              result_nx_s = acc_step_s;
            end
          end else begin
            state_nx_s = MulOn;
          end
        end
      end

      MulEnd: begin
        if (mul.start_i == MulStop) begin
          state_nx_s = MulFree;
        end else begin
          state_nx_s  = MulEnd;
          ready_nx_s  = MulResultReady;
          result_nx_s = result_r;
        end
      end

      // MulFree and the unreachable 2'b11 encoding
      default: begin
        if ((mul.start_i == MulStart) && (mul.annul_i == 1'b0)) begin
          if ((mul.opdata1_i == ZeroWord) || (mul.opdata2_i == ZeroWord)) begin
            state_nx_s = MulEnd;
            ready_nx_s = MulResultReady;
          end else begin
            state_nx_s  = MulOn;
            mcand_nx_s  = {ZeroWord, mag1_s};
            mplier_nx_s = mag2_s;
            neg_nx_s    = mul.signed_mul_i & (mul.opdata1_i[31] ^ mul.opdata2_i[31]);
            acc_nx_s    = ZeroDword;
            cnt_nx_s    = 5'd0;
          end
        end else begin
          state_nx_s = MulFree;
        end
      end
    endcase
  end

  // State and output registers; rst wins over every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= MulFree;
      acc_r    <= ZeroDword;
      mcand_r  <= ZeroDword;
      mplier_r <= ZeroWord;
      cnt_r    <= 5'd0;
      neg_r    <= 1'b0;
      result_r <= ZeroDword;
      ready_r  <= MulResultNotReady;
    end else begin
      state_r  <= state_nx_s;
      acc_r    <= acc_nx_s;
      mcand_r  <= mcand_nx_s;
      mplier_r <= mplier_nx_s;
      cnt_r    <= cnt_nx_s;
      neg_r    <= neg_nx_s;
      result_r <= result_nx_s;
      ready_r  <= ready_nx_s;
    end
  end

  assign mul.result_o = result_r;
  assign mul.ready_o  = ready_r;

endmodule

// File: tb/tb_mul_iter.sv
// Directed self-checking bench for mul_iter: latency, signed/unsigned products,
// zero shortcut, annul, mid-operation reset, MulEnd hold and back-to-back requests.
module tb_mul_iter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mul_iter_if mif();

  mul_iter dut (
    .clk (clk),
    .rst (rst),
    .mul (mif.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    mif.signed_mul_i = sgn;
    mif.opdata1_i    = a;
    mif.opdata2_i    = b;
    mif.annul_i      = 1'b0;
    mif.start_i      = 1'b1;
  endtask

  // Counts cycles after the accept cycle until ready_o; -1 when the budget runs out
  task automatic wait_ready(input int budget, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while ((mif.ready_o !== 1'b1) && (cycles < budget));
    if (mif.ready_o !== 1'b1) cycles = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mif.signed_mul_i = 1'b0;
    mif.opdata1_i = 32'd0;
    mif.opdata2_i = 32'd0;
    mif.start_i = 1'b0;
    mif.annul_i = 1'b0;
    tick();
    tick();
    checks++;
    if (mif.ready_o !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b expected 0", mif.ready_o);
    end
    checks++;
    if (mif.result_o !== 64'd0) begin
      errors++; $display("FAIL reset_result: got %h expected 0", mif.result_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unsigned_max();
    int lat;
    drive_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_ready(40, lat);
    checks++;
    if (lat !== 33) begin
      errors++; $display("FAIL umax_latency: got %0d expected 33", lat);
    end
    checks++;
    if (mif.result_o !== 64'hFFFF_FFFE_0000_0001) begin
      errors++; $display("FAIL umax_result: got %h expected fffffffe00000001", mif.result_o);
    end
    mif.start_i = 1'b0;
    tick();
    checks++;
    if (mif.ready_o !== 1'b0) begin
      errors++; $display("FAIL umax_ready_drop: got %b expected 0", mif.ready_o);
    end
    checks++;
    if (mif.result_o !== 64'd0) begin
      errors++; $display("FAIL umax_result_drop: got %h expected 0", mif.result_o);
    end
  endtask

  task automatic test_signed();
    logic        sgn_v [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] a_v   [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB};
    logic [31:0] b_v   [4] = '{32'd7, 32'd1, 32'd1, 32'hFFFF_FFFA};
    logic [63:0] exp_v [4] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_8000_0000,
                               64'h0000_0000_8000_0000, 64'h0000_0000_0000_001E};
    int lat;
    for (int i = 0; i < 4; i++) begin
      drive_op(sgn_v[i], a_v[i], b_v[i]);
      wait_ready(40, lat);
      checks++;
      if (lat !== 33) begin
        errors++; $display("FAIL signed_latency[%0d]: got %0d expected 33", i, lat);
      end
      checks++;
      if (mif.result_o !== exp_v[i]) begin
        errors++; $display("FAIL signed_result[%0d]: got %h expected %h", i, mif.result_o, exp_v[i]);
      end
      mif.start_i = 1'b0;
      tick();
    end
  endtask

  task automatic test_zero();
    int lat;
    for (int i = 0; i < 4; i++) begin
      if (i < 2) drive_op(i[0], 32'd0, 32'h1234_5678);
      else       drive_op(i[0], 32'h1234_5678, 32'd0);
      wait_ready(40, lat);
      checks++;
      if (lat !== 1) begin
        errors++; $display("FAIL zero_latency[%0d]: got %0d expected 1", i, lat);
      end
      checks++;
      if (mif.result_o !== 64'd0) begin
        errors++; $display("FAIL zero_result[%0d]: got %h expected 0", i, mif.result_o);
      end
      mif.start_i = 1'b0;
      tick();
    end
  endtask

  task automatic test_annul();
    int lat;
    int pulses = 0;
    drive_op(1'b0, 32'd100, 32'd200);
    repeat (10) begin
      tick();
      if (mif.ready_o === 1'b1) pulses++;
    end
    mif.annul_i = 1'b1;
    tick();
    mif.annul_i = 1'b0;
    mif.start_i = 1'b0;
    checks++;
    if (mif.result_o !== 64'd0) begin
      errors++; $display("FAIL annul_result: got %h expected 0", mif.result_o);
    end
    repeat (40) begin
      tick();
      if (mif.ready_o === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL annul_no_ready: got %0d pulses expected 0", pulses);
    end
    drive_op(1'b0, 32'd6, 32'd7);
    wait_ready(40, lat);
    checks++;
    if (lat !== 33) begin
      errors++; $display("FAIL annul_next_latency: got %0d expected 33", lat);
    end
    checks++;
    if (mif.result_o !== 64'h0000_0000_0000_002A) begin
      errors++; $display("FAIL annul_next_result: got %h expected 2a", mif.result_o);
    end
    mif.start_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    drive_op(1'b1, 32'hFFFF_FFFD, 32'd9);
    repeat (20) begin
      tick();
      if (mif.ready_o === 1'b1) pulses++;
    end
    rst = 1'b1;
    tick();
    checks++;
    if (mif.ready_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_ready: got %b expected 0", mif.ready_o);
    end
    checks++;
    if (mif.result_o !== 64'd0) begin
      errors++; $display("FAIL rstmid_result: got %h expected 0", mif.result_o);
    end
    rst = 1'b0;
    mif.start_i = 1'b0;
    repeat (40) begin
      tick();
      if (mif.ready_o === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL rstmid_no_ready: got %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_hold();
    int lat;
    drive_op(1'b0, 32'h0001_0000, 32'h0001_0000);
    tick();
    // Operands and signedness change after accept and must be ignored
    mif.signed_mul_i = 1'b1;
    mif.opdata1_i = 32'hFFFF_FFFF;
    mif.opdata2_i = 32'h8000_0000;
    wait_ready(40, lat);
    checks++;
    if (lat + 1 !== 33) begin
      errors++; $display("FAIL hold_latency: got %0d expected 33", lat + 1);
    end
    checks++;
    if (mif.result_o !== 64'h0000_0001_0000_0000) begin
      errors++; $display("FAIL hold_result: got %h expected 0000000100000000", mif.result_o);
    end
    mif.annul_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mif.ready_o !== 1'b1) begin
        errors++; $display("FAIL hold_ready[%0d]: got %b expected 1", i, mif.ready_o);
      end
      checks++;
      if (mif.result_o !== 64'h0000_0001_0000_0000) begin
        errors++; $display("FAIL hold_stable[%0d]: got %h expected 0000000100000000", i, mif.result_o);
      end
    end
    mif.annul_i = 1'b0;
    mif.start_i = 1'b0;
    tick();
    checks++;
    if (mif.ready_o !== 1'b0) begin
      errors++; $display("FAIL hold_release: got %b expected 0", mif.ready_o);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    drive_op(1'b0, 32'h0001_0000, 32'd3);
    wait_ready(40, lat);
    checks++;
    if ((lat !== 33) || (mif.result_o !== 64'h0000_0000_0003_0000)) begin
      errors++; $display("FAIL b2b_first: got lat %0d result %h expected lat 33 result 30000", lat, mif.result_o);
    end
    mif.start_i = 1'b0;
    tick();
    checks++;
    if (mif.ready_o !== 1'b0) begin
      errors++; $display("FAIL b2b_gap_ready: got %b expected 0", mif.ready_o);
    end
    drive_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_ready(40, lat);
    checks++;
    if (lat !== 33) begin
      errors++; $display("FAIL b2b_second_latency: got %0d expected 33", lat);
    end
    checks++;
    if (mif.result_o !== 64'h0000_0000_0000_0001) begin
      errors++; $display("FAIL b2b_second_result: got %h expected 1", mif.result_o);
    end
    mif.start_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_zero();
    test_annul();
    test_reset_mid();
    test_hold();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
